adc_spi_sampler: RTL and testbench
==================================

# adc_spi_sampler

Producer side of the sample interface: drives an external 8-channel, 10-bit SPI ADC (MCP3008 framing), converting whichever channel the downstream consumer requests. Each completed conversion is delivered as a one-cycle `new_sample` strobe with `sample` and `sample_channel`, feeding the data-processing block. Conversions run back to back while `enable` is high.

## Interface
- `CLK_DIV`, default 4: clk cycles per SCK half-period; legal range 2..255.
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `enable`  in  1  start new conversion frames while high
- `channel`  in  4  requested channel, sampled at frame start
- `new_sample`  out  1  one-cycle strobe; conversion result valid
- `sample`  out  10  conversion result, held until next strobe
- `sample_channel`  out  4  channel that `sample` belongs to
- `spi_cs_n`  out  1  ADC chip select, active low
- `spi_sck`  out  1  SPI clock, mode 0 (idle low)
- `spi_mosi`  out  1  command bits to ADC
- `spi_miso`  in  1  result bits from ADC; treated as synchronous to `clk`

## Operation
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `new_sample`=0, `sample`=0, `sample_channel`=0, FSM in IDLE. Reset asserted mid-frame aborts immediately; CS rises asynchronously, with no strobe and no partial result.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - IDLE: if `enable`=1, latch `channel` and go to SETUP; else stay.
  - Latched `channel[3]`=1 is invalid: return to IDLE without a frame or strobe; re-evaluate on the next cycle.
  - SETUP: `spi_cs_n`=0, MOSI = first bit; lasts CLK_DIV cycles.
  - SHIFT: 17 SCK periods; frame bits are numbered 1..17.
    - MOSI drives bit 1=1 (start), bit 2=1 (single-ended), bits 3..5 = ch[2:0], then 0.
    - MOSI changes only while SCK is low, at the falling edge.
    - MISO is sampled on the clk of each SCK rising edge. Bits 1..7 are discarded: command, sample period, null. Bits 8..17 = result[9:0], MSB first.
  - HOLD: SCK low, CS low for CLK_DIV cycles. On entry, `sample` and `sample_channel` update and `new_sample`=1 for exactly one cycle.
  - GAP: CS high for 2*CLK_DIV cycles (minimum CS-high time), then IDLE.
- `enable` deasserted mid-frame: the frame completes and strobes normally, then the FSM stays in IDLE.
- `channel` changes mid-frame are ignored until the next IDLE latch.

## Timing
- SCK period = 2*CLK_DIV clk cycles; 50% duty.
- Frame length = CLK_DIV (SETUP) + 34*CLK_DIV (SHIFT) + CLK_DIV (HOLD) + 2*CLK_DIV (GAP) + 1 (IDLE) = 38*CLK_DIV+1 cycles. That is 153 cycles at the default.
- Latency: `spi_cs_n` fall to `new_sample` = 35*CLK_DIV cycles.
- Strobe spacing with `enable` held high is exactly 38*CLK_DIV+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `ADC_SPI_AVG4_EN` defined:
  - Four consecutive frames on the same channel are summed in a 12-bit accumulator.
  - `new_sample` strobes only after the 4th frame, with `sample` = sum[11:2] (truncating).
  - A frame whose latched channel differs from the accumulator's channel restarts the accumulator with that frame as count 1.
  - Reset clears the accumulator and count.
- Not defined: every frame strobes its raw 10-bit result; no accumulator logic is present.

## Test plan
- Reset then `enable`=1, `channel`=3, ADC model returns 10'h2A5 -> MOSI bits 1,1,0,1,1; `new_sample` one cycle at 140 cycles after CS falls (CLK_DIV=4); `sample`=10'h2A5, `sample_channel`=3.
- `enable` held, `channel` switched 0->5 during SHIFT of the first frame -> first strobe `sample_channel`=0, second strobe `sample_channel`=5; strobes 153 cycles apart.
- `channel`=9 with `enable`=1 -> `spi_cs_n` stays 1, no strobe; switching to `channel`=1 starts a frame on the next cycle.
- `rst` pulsed at SHIFT bit 12 -> `spi_cs_n`=1 and `spi_sck`=0 immediately, no strobe, `sample`=0; the next frame after release completes correctly.
- `enable` dropped during SETUP -> that frame still strobes; no further CS activity for 1000 cycles.
- With `ADC_SPI_AVG4_EN`, ch2 results 100, 101, 102, 104 -> a single strobe after the 4th frame with `sample`=101; a ch change after frame 2 -> no strobe until 4 frames on the new channel.

Source files
------------

// File: rtl/adc_spi_sampler_if.sv
// Sample interface between the ADC sampler (producer) and the
// data-processing block (consumer). The consumer requests a channel and
// enables conversions. The producer returns a strobed result tagged with
// the channel it belongs to.
interface adc_spi_sampler_if;
  logic       enable;
  logic [3:0] channel;
  logic       new_sample;
  logic [9:0] sample;
  logic [3:0] sample_channel;

  modport master (
    input  enable,
    input  channel,
    output new_sample,
    output sample,
    output sample_channel
  );

  modport slave (
    output enable,
    output channel,
    input  new_sample,
    input  sample,
    input  sample_channel
  );
endinterface

// File: rtl/adc_spi_sampler.sv
// MCP3008-style SPI ADC sampler. It runs back-to-back 17-bit frames while
// enable is high and strobes each 10-bit result with the channel that
// produced it.
// Optional feature macro: ADC_SPI_AVG4_EN. When it is defined, results are
// averaged over four consecutive frames on the same channel before they
// are strobed.
module adc_spi_sampler #(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  adc_spi_sampler_if.master smp,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

  state_t     state, state_nxt;
  logic [8:0] cnt, cnt_nxt;
  logic [5:0] half, half_nxt;
  logic [3:0] ch_q;
  logic [9:0] shreg;
  logic       cs_n_nxt, sck_nxt, mosi_nxt;
  logic       start, rise, done;

  // Command bit n of the frame: start, single-ended, then the channel, then zeros.
  function automatic logic cmd_bit(input logic [5:0] n, input logic [2:0] ch);
    case (n)
      6'd1, 6'd2: cmd_bit = 1'b1;
      6'd3:       cmd_bit = ch[2];
      6'd4:       cmd_bit = ch[1];
      6'd5:       cmd_bit = ch[0];
      default:    cmd_bit = 1'b0;
    endcase
  endfunction

  // Next state plus next values of the registered SPI pins. Even half-periods of SHIFT are SCK high.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 9'd1;
    half_nxt  = half;
    cs_n_nxt  = 1'b1;
    sck_nxt   = 1'b0;
    mosi_nxt  = spi_mosi;
    start     = 1'b0;
    rise      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt  = 9'd0;
        mosi_nxt = 1'b0;
        if (smp.enable && !smp.channel[3]) begin
          state_nxt = SETUP;
          start     = 1'b1;
          cs_n_nxt  = 1'b0;
          mosi_nxt  = 1'b1;
        end
      end
      SETUP: begin
        cs_n_nxt = 1'b0;
        if (cnt == DIV_LAST) begin
          state_nxt = SHIFT;
          cnt_nxt   = 9'd0;
          half_nxt  = 6'd0;
          sck_nxt   = 1'b1;
          rise      = 1'b1;
        end
      end
      SHIFT: begin
        cs_n_nxt = 1'b0;
        sck_nxt  = ~half[0];
        if (cnt == DIV_LAST) begin
          cnt_nxt = 9'd0;
          if (half == 6'd33) begin
            state_nxt = HOLD;
            sck_nxt   = 1'b0;
            mosi_nxt  = 1'b0;
            done      = 1'b1;
          end else begin
            half_nxt = half + 6'd1;
            sck_nxt  = half[0];
            if (half[0]) begin
              rise = 1'b1;
            end else begin
              mosi_nxt = cmd_bit({1'b0, half[5:1]} + 6'd2, ch_q[2:0]);
            end
          end
        end
      end
      HOLD: begin
        mosi_nxt = 1'b0;
        if (cnt == DIV_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = 9'd0;
        end else begin
          cs_n_nxt = 1'b0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = 9'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer registers, SPI pins, latched channel and the MISO shifter (17 shifts leave bits 8..17).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 9'd0;
      half     <= 6'd0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      ch_q     <= 4'd0;
      shreg    <= 10'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      half     <= half_nxt;
      spi_cs_n <= cs_n_nxt;
      spi_sck  <= sck_nxt;
      spi_mosi <= mosi_nxt;
      if (start) ch_q <= smp.channel;
      if (rise) shreg <= {shreg[8:0], spi_miso};
    end
  end

`ifdef ADC_SPI_AVG4_EN
  logic [11:0] acc;
  logic [11:0] sum;
  logic [1:0]  acc_cnt;
  logic [3:0]  acc_ch;

  // Running sum including the frame that just completed.
  always_comb begin
    sum = acc + {2'b00, shreg};
  end

  // Accumulate four same-channel frames. A channel change restarts the sum with the current frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp.new_sample     <= 1'b0;
      smp.sample         <= 10'd0;
      smp.sample_channel <= 4'd0;
      acc                <= 12'd0;
      acc_cnt            <= 2'd0;
      acc_ch             <= 4'd0;
    end else begin
      smp.new_sample <= 1'b0;
      if (done) begin
        if (acc_cnt != 2'd0 && acc_ch == ch_q) begin
          if (acc_cnt == 2'd3) begin
            smp.new_sample     <= 1'b1;
            smp.sample         <= sum[11:2];
            smp.sample_channel <= ch_q;
            acc                <= 12'd0;
            acc_cnt            <= 2'd0;
          end else begin
            acc     <= sum;
            acc_cnt <= acc_cnt + 2'd1;
          end
        end else begin
          acc     <= {2'b00, shreg};
          acc_cnt <= 2'd1;
          acc_ch  <= ch_q;
        end
      end
    end
  end
`else
  // Every completed frame strobes its raw result on entry to HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp.new_sample     <= 1'b0;
      smp.sample         <= 10'd0;
      smp.sample_channel <= 4'd0;
    end else begin
      smp.new_sample <= done;
      if (done) begin
        smp.sample         <= shreg;
        smp.sample_channel <= ch_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Testbench for adc_spi_sampler. A behavioural MCP3008 model answers each
// frame. Expected results go into a scoreboard queue when a frame is
// requested, and are compared against the strobes the DUT delivers.
`timescale 1ns/1ps
module tb_adc_spi_sampler;
  localparam int CLK_DIV = 4;
  localparam int LATENCY = 35 * CLK_DIV;
  localparam int FRAME   = 38 * CLK_DIV + 1;
  localparam int BUDGET  = FRAME + 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_cs_n, spi_sck, spi_mosi;
  logic spi_miso = 1'b0;

  adc_spi_sampler_if sif ();

  adc_spi_sampler #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .smp      (sif),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [9:0] value; logic [3:0] chan; } exp_t;
  typedef struct { logic [9:0] value; logic [3:0] chan; int cyc; } got_t;

  exp_t        exp_q[$];
  got_t        got_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [9:0]  adc_val = '0;
  int          fall_cnt = 0;
  int          rise_cnt = 0;
  int          cs_fall_cnt = 0;
  int          cs_fall_cyc = 0;
  logic [16:0] mosi_bits = '0;
  logic        sck_d = 1'b0;
  logic        cs_d = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC frame bit k: 1s through the command/null slots, then the result MSB first.
  function automatic logic miso_bit(input int k, input logic [9:0] v);
    if (k < 8) return 1'b1;
    if (k <= 17) return v[17 - k];
    return 1'b0;
  endfunction

  // ADC model plus strobe capture, evaluated mid-cycle so nothing races the DUT.
  always @(negedge clk) begin
    if (sck_d && !spi_sck) begin
      fall_cnt = fall_cnt + 1;
      spi_miso = miso_bit(fall_cnt + 1, adc_val);
    end
    if (!sck_d && spi_sck) begin
      rise_cnt = rise_cnt + 1;
      if (rise_cnt <= 17) mosi_bits = {mosi_bits[15:0], spi_mosi};
    end
    if (cs_d && !spi_cs_n) begin
      fall_cnt    = 0;
      rise_cnt    = 0;
      mosi_bits   = '0;
      spi_miso    = miso_bit(1, adc_val);
      cs_fall_cnt = cs_fall_cnt + 1;
      cs_fall_cyc = cyc;
    end
    if (sif.new_sample === 1'b1)
      got_q.push_back('{value: sif.sample, chan: sif.sample_channel, cyc: cyc});
    sck_d = spi_sck;
    cs_d  = spi_cs_n;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_cs_fall(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(negedge clk); #1;
      if (cs_fall_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(negedge clk); #1;
      if (got_q.size() > 0) ok = 1'b1;
    end
  endtask

  task automatic wait_rise(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(negedge clk); #1;
      if (rise_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    sif.enable  = 1'b0;
    sif.channel = 4'd0;
    rst = 1'b1;
    idle(3);
    checks += 6;
    if (spi_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n got %b want 1", spi_cs_n); end
    if (spi_sck !== 1'b0) begin errors++; $display("[TB] FAIL reset_sck got %b want 0", spi_sck); end
    if (spi_mosi !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi got %b want 0", spi_mosi); end
    if (sif.new_sample !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe got %b want 0", sif.new_sample); end
    if (sif.sample !== 10'd0) begin errors++; $display("[TB] FAIL reset_sample got %h want 0", sif.sample); end
    if (sif.sample_channel !== 4'd0) begin errors++; $display("[TB] FAIL reset_channel got %h want 0", sif.sample_channel); end
    rst = 1'b0;
    idle(4);
  endtask

`ifndef ADC_SPI_AVG4_EN
  task automatic test_basic();
    bit ok; got_t g; exp_t e; logic [2:0] ch; logic [16:0] want_mosi;
    ch = 3'd3;
    want_mosi = {2'b11, ch, 12'd0};
    adc_val = 10'h2A5;
    exp_q.push_back('{value: 10'h2A5, chan: 4'd3});
    sif.channel = 4'd3;
    sif.enable  = 1'b1;
    wait_cs_fall(cs_fall_cnt + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL basic_cs_timeout got none want cs fall"); end
    wait_strobe(ok);
    sif.enable = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL basic_strobe_timeout got none want strobe");
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks += 5;
      if (g.value !== e.value) begin errors++; $display("[TB] FAIL basic_sample got %h want %h", g.value, e.value); end
      if (g.chan !== e.chan) begin errors++; $display("[TB] FAIL basic_channel got %0d want %0d", g.chan, e.chan); end
      if (g.cyc - cs_fall_cyc != LATENCY) begin errors++; $display("[TB] FAIL basic_latency got %0d want %0d", g.cyc - cs_fall_cyc, LATENCY); end
      if (mosi_bits !== want_mosi) begin errors++; $display("[TB] FAIL basic_mosi got %b want %b", mosi_bits, want_mosi); end
      if (rise_cnt != 17) begin errors++; $display("[TB] FAIL basic_sck_count got %0d want 17", rise_cnt); end
    end
    idle(FRAME);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("[TB] FAIL basic_single_strobe got %0d extra want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_channel_switch();
    bit ok; got_t g; exp_t e; int t1;
    t1 = 0;
    adc_val = 10'h0F0;
    exp_q.push_back('{value: 10'h0F0, chan: 4'd0});
    exp_q.push_back('{value: 10'h1C3, chan: 4'd5});
    sif.channel = 4'd0;
    sif.enable  = 1'b1;
    wait_cs_fall(cs_fall_cnt + 1, ok);
    idle(40);
    sif.channel = 4'd5;
    wait_strobe(ok);
    adc_val = 10'h1C3;
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL switch_strobe1_timeout got none want strobe");
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front(); t1 = g.cyc;
      checks += 2;
      if (g.value !== e.value) begin errors++; $display("[TB] FAIL switch_sample1 got %h want %h", g.value, e.value); end
      if (g.chan !== e.chan) begin errors++; $display("[TB] FAIL switch_channel1 got %0d want %0d", g.chan, e.chan); end
    end
    wait_cs_fall(cs_fall_cnt + 1, ok);
    sif.enable = 1'b0;
    wait_strobe(ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL switch_strobe2_timeout got none want strobe");
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks += 3;
      if (g.value !== e.value) begin errors++; $display("[TB] FAIL switch_sample2 got %h want %h", g.value, e.value); end
      if (g.chan !== e.chan) begin errors++; $display("[TB] FAIL switch_channel2 got %0d want %0d", g.chan, e.chan); end
      if (g.cyc - t1 != FRAME) begin errors++; $display("[TB] FAIL switch_spacing got %0d want %0d", g.cyc - t1, FRAME); end
    end
    idle(FRAME);
  endtask

  task automatic test_invalid_channel();
    bit ok; got_t g; exp_t e; int base; int c;
    base = cs_fall_cnt;
    sif.channel = 4'd9;
    sif.enable  = 1'b1;
    idle(200);
    checks += 2;
    if (cs_fall_cnt != base || spi_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL invalid_no_frame got %0d frames want 0", cs_fall_cnt - base); end
    if (got_q.size() != 0) begin errors++; $display("[TB] FAIL invalid_no_strobe got %0d want 0", got_q.size()); got_q.delete(); end
    adc_val = 10'h3C0;
    exp_q.push_back('{value: 10'h3C0, chan: 4'd1});
    c = cyc;
    sif.channel = 4'd1;
    wait_cs_fall(base + 1, ok);
    sif.enable = 1'b0;
    checks++;
    if (!ok || cs_fall_cyc != c + 1) begin errors++; $display("[TB] FAIL invalid_restart got %0d want %0d", cs_fall_cyc, c + 1); end
    wait_strobe(ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL invalid_strobe_timeout got none want strobe");
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks += 2;
      if (g.value !== e.value) begin errors++; $display("[TB] FAIL invalid_sample got %h want %h", g.value, e.value); end
      if (g.chan !== e.chan) begin errors++; $display("[TB] FAIL invalid_channel got %0d want %0d", g.chan, e.chan); end
    end
    idle(FRAME);
  endtask

  task automatic test_reset_mid_frame();
    bit ok; got_t g; exp_t e; int base;
    adc_val = 10'h2DB;
    sif.channel = 4'd6;
    sif.enable  = 1'b1;
    wait_cs_fall(cs_fall_cnt + 1, ok);
    sif.enable = 1'b0;
    wait_rise(12, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL midrst_bit12_timeout got %0d rises want 12", rise_cnt); end
    rst = 1'b1;
    #1;
    checks += 4;
    if (spi_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL midrst_cs_n got %b want 1", spi_cs_n); end
    if (spi_sck !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sck got %b want 0", spi_sck); end
    if (sif.new_sample !== 1'b0) begin errors++; $display("[TB] FAIL midrst_strobe got %b want 0", sif.new_sample); end
    if (sif.sample !== 10'd0) begin errors++; $display("[TB] FAIL midrst_sample got %h want 0", sif.sample); end
    idle(3);
    rst = 1'b0;
    base = cs_fall_cnt;
    idle(200);
    checks++;
    if (got_q.size() != 0 || cs_fall_cnt != base) begin errors++; $display("[TB] FAIL midrst_quiet got %0d strobes want 0", got_q.size()); got_q.delete(); end
    adc_val = 10'h155;
    exp_q.push_back('{value: 10'h155, chan: 4'd2});
    sif.channel = 4'd2;
    sif.enable  = 1'b1;
    wait_cs_fall(base + 1, ok);
    sif.enable = 1'b0;
    wait_strobe(ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL midrst_strobe_timeout got none want strobe");
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks += 2;
      if (g.value !== e.value) begin errors++; $display("[TB] FAIL midrst_sample_after got %h want %h", g.value, e.value); end
      if (g.chan !== e.chan) begin errors++; $display("[TB] FAIL midrst_channel_after got %0d want %0d", g.chan, e.chan); end
    end
    idle(FRAME);
  endtask

  task automatic test_enable_drop();
    bit ok; got_t g; exp_t e; int base;
    adc_val = 10'h3FF;
    exp_q.push_back('{value: 10'h3FF, chan: 4'd7});
    sif.channel = 4'd7;
    sif.enable  = 1'b1;
    wait_cs_fall(cs_fall_cnt + 1, ok);
    sif.enable = 1'b0;
    wait_strobe(ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL drop_strobe_timeout got none want strobe");
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks += 2;
      if (g.value !== e.value) begin errors++; $display("[TB] FAIL drop_sample got %h want %h", g.value, e.value); end
      if (g.chan !== e.chan) begin errors++; $display("[TB] FAIL drop_channel got %0d want %0d", g.chan, e.chan); end
    end
    base = cs_fall_cnt;
    idle(1000);
    checks += 2;
    if (cs_fall_cnt != base || spi_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL drop_quiet got %0d frames want 0", cs_fall_cnt - base); end
    if (got_q.size() != 0) begin errors++; $display("[TB] FAIL drop_no_strobe got %0d want 0", got_q.size()); got_q.delete(); end
  endtask
`else
  task automatic avg_frame(input logic [3:0] ch, input logic [9:0] v, input bit last, input int want_strobes);
    bit ok;
    adc_val     = v;
    sif.channel = ch;
    sif.enable  = 1'b1;
    wait_cs_fall(cs_fall_cnt + 1, ok);
    if (last) sif.enable = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL avg_cs_timeout got none want cs fall"); end
    wait_rise(17, ok);
    idle(3 * CLK_DIV);
    checks++;
    if (!ok || got_q.size() != want_strobes) begin errors++; $display("[TB] FAIL avg_strobe_count got %0d want %0d", got_q.size(), want_strobes); end
  endtask

  task automatic test_avg4();
    got_t g; exp_t e; int sum;
    logic [9:0] vals [4];
    logic [9:0] vals_b [4];
    vals   = '{10'd100, 10'd101, 10'd102, 10'd104};
    vals_b = '{10'd8, 10'd8, 10'd9, 10'd10};
    sum = 0;
    foreach (vals[i]) sum += int'(vals[i]);
    exp_q.push_back('{value: 10'(sum >> 2), chan: 4'd2});
    for (int i = 0; i < 4; i++) avg_frame(4'd2, vals[i], i == 3, (i == 3) ? 1 : 0);
    if (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks += 2;
      if (g.value !== e.value) begin errors++; $display("[TB] FAIL avg_sample got %0d want %0d", g.value, e.value); end
      if (g.chan !== e.chan) begin errors++; $display("[TB] FAIL avg_channel got %0d want %0d", g.chan, e.chan); end
    end
    got_q.delete();
    idle(FRAME);
    sum = 0;
    foreach (vals_b[i]) sum += int'(vals_b[i]);
    exp_q.push_back('{value: 10'(sum >> 2), chan: 4'd4});
    avg_frame(4'd1, 10'd500, 1'b0, 0);
    avg_frame(4'd1, 10'd500, 1'b0, 0);
    for (int i = 0; i < 4; i++) avg_frame(4'd4, vals_b[i], i == 3, (i == 3) ? 1 : 0);
    if (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks += 2;
      if (g.value !== e.value) begin errors++; $display("[TB] FAIL avg_restart_sample got %0d want %0d", g.value, e.value); end
      if (g.chan !== e.chan) begin errors++; $display("[TB] FAIL avg_restart_channel got %0d want %0d", g.chan, e.chan); end
    end
    got_q.delete();
    idle(FRAME);
  endtask
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] adc_spi_sampler bench, CLK_DIV=%0d", CLK_DIV);
    test_reset();
`ifdef ADC_SPI_AVG4_EN
    test_avg4();
`else
    test_basic();
    test_channel_switch();
    test_invalid_channel();
    test_reset_mid_frame();
    test_enable_drop();
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drain got %0d pending want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
